// File: rtl/ror_lsr_pipe_pkg.sv
// Shared ALU shifter definitions: operand width, shift width and op-code encoding.
package ror_lsr_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int SH_W   = $clog2(DATA_W);

    typedef logic [1:0] shr_op_t;

    localparam shr_op_t SHR_LSR  = 2'b00;
    localparam shr_op_t SHR_ASR  = 2'b01;
    localparam shr_op_t SHR_ROR  = 2'b10;
    localparam shr_op_t SHR_PASS = 2'b11;

endpackage

// File: rtl/ror_lsr_stage.sv
// One combinational step of the logarithmic right shifter: conditionally
// shifts by a fixed SHIFT, choosing fill bits by op and updating the carry.
module ror_lsr_stage
    import ror_lsr_pipe_pkg::*;
#(
    parameter int SHIFT = 1
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_sh,
    input  shr_op_t           i_op,
    input  logic              i_sign,
    input  logic              i_carry,
    output logic [DATA_W-1:0] o_data,
    output logic              o_carry
);

    logic [SHIFT-1:0] w_fill;

    always_comb begin
        w_fill  = '0;
        o_data  = i_data;
        o_carry = i_carry;
        case (i_op)
            SHR_ASR: w_fill = {SHIFT{i_sign}};
            SHR_ROR: w_fill = i_data[SHIFT-1:0];
            default: w_fill = '0;
        endcase
        // The carry is the last bit to leave the bottom of the word.
        if (i_sh && (i_op != SHR_PASS)) begin
            o_data  = {w_fill, i_data[DATA_W-1:SHIFT]};
            o_carry = i_data[SHIFT-1];
        end
    end

endmodule

// File: rtl/ror_lsr_pipe.sv
// Five-stage (16/8/4/2/1) pipelined LSR/ASR/ROR unit with valid/ready on both
// sides; the whole pipe freezes under output backpressure, flush kills it.
module ror_lsr_pipe
    import ror_lsr_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [SH_W-1:0]   in_shift,
    input  shr_op_t           in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carry
);

    localparam int NSTG = SH_W;

    logic              r_vld   [NSTG];
    logic [DATA_W-1:0] r_data  [NSTG];
    logic [SH_W-1:0]   r_sh    [NSTG];
    shr_op_t           r_op    [NSTG];
    logic              r_sign  [NSTG];
    logic              r_carry [NSTG];

    logic [DATA_W-1:0] w_data  [NSTG];
    logic              w_carry [NSTG];
    logic              w_stall;
    logic              w_unused;

    assign w_stall  = r_vld[NSTG-1] & ~out_ready;
    assign in_ready = ~w_stall & ~flush;

    genvar g;
    generate
        for (g = 0; g < NSTG; g++) begin : g_stage
            if (g == 0) begin : g_first
                ror_lsr_stage #(.SHIFT(DATA_W >> 1)) u_stage (
                    .i_data  (in_a),
                    .i_sh    (in_shift[SH_W-1]),
                    .i_op    (in_op),
                    .i_sign  (in_a[DATA_W-1]),
                    .i_carry (1'b0),
                    .o_data  (w_data[0]),
                    .o_carry (w_carry[0])
                );
            end else begin : g_rest
                ror_lsr_stage #(.SHIFT((DATA_W >> 1) >> g)) u_stage (
                    .i_data  (r_data[g-1]),
                    .i_sh    (r_sh[g-1][SH_W-1-g]),
                    .i_op    (r_op[g-1]),
                    .i_sign  (r_sign[g-1]),
                    .i_carry (r_carry[g-1]),
                    .o_data  (w_data[g]),
                    .o_carry (w_carry[g])
                );
            end
        end
    endgenerate

    // Flush only clears valids; stale data is harmless behind valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                r_vld[k]   <= 1'b0;
                r_data[k]  <= '0;
                r_sh[k]    <= '0;
                r_op[k]    <= SHR_LSR;
                r_sign[k]  <= 1'b0;
                r_carry[k] <= 1'b0;
            end
        end else if (flush) begin
            for (int k = 0; k < NSTG; k++) begin
                r_vld[k] <= 1'b0;
            end
        end else if (!w_stall) begin
            r_vld[0]   <= in_valid;
            r_data[0]  <= w_data[0];
            r_sh[0]    <= in_shift;
            r_op[0]    <= in_op;
            r_sign[0]  <= in_a[DATA_W-1];
            r_carry[0] <= w_carry[0];
            for (int k = 1; k < NSTG; k++) begin
                r_vld[k]   <= r_vld[k-1];
                r_data[k]  <= w_data[k];
                r_sh[k]    <= r_sh[k-1];
                r_op[k]    <= r_op[k-1];
                r_sign[k]  <= r_sign[k-1];
                r_carry[k] <= w_carry[k];
            end
        end
    end

    assign out_valid  = r_vld[NSTG-1];
    assign out_result = r_data[NSTG-1];
    assign out_carry  = r_carry[NSTG-1];

    assign w_unused = ^{r_sh[NSTG-1], r_op[NSTG-1], r_sign[NSTG-1]};

endmodule

// File: tb/tb_ror_lsr_pipe.sv
// Bench for ror_lsr_pipe: directed cases, randomized streaming with backpressure
// against an arithmetic reference model, flush and mid-stream reset.
module tb_ror_lsr_pipe;
    import ror_lsr_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [4:0]  in_shift;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carry;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_res[$];
    logic        q_c[$];

    ror_lsr_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_shift   (in_shift),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry)
    );

    always #5 clk = ~clk;

    function automatic void ref_shift(input logic [31:0] a, input int sh, input logic [1:0] op,
                                      output logic [31:0] r, output logic c);
        logic [63:0] dbl;
        r = a;
        c = 1'b0;
        if (op == 2'b11 || sh == 0) return;
        case (op)
            2'b00: r = a >> sh;
            2'b01: r = $unsigned($signed(a) >>> sh);
            default: begin
                dbl = {a, a} >> sh;
                r   = dbl[31:0];
            end
        endcase
        c = a[sh-1];
    endfunction

    task automatic run_one(input string name, input logic [31:0] a, input logic [4:0] sh,
                           input logic [1:0] op, input logic [31:0] exp_r, input logic exp_c);
        int n;
        @(posedge clk); #1;
        in_a = a; in_shift = sh; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(posedge clk); n++; @(negedge clk);
        end
        checks++;
        if (n !== 5) begin
            failures++; $display("FAIL %s_latency: got %0d expected 5", name, n);
        end
        checks++;
        if (out_result !== exp_r) begin
            failures++; $display("FAIL %s_result: got %h expected %h", name, out_result, exp_r);
        end
        checks++;
        if (out_carry !== exp_c) begin
            failures++; $display("FAIL %s_carry: got %b expected %b", name, out_carry, exp_c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_shift = '0; in_op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_result, out_carry, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset: got v=%b r=%h c=%b rdy=%b expected v=0 r=0 c=0 rdy=1",
                     out_valid, out_result, out_carry, in_ready);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_directed();
        run_one("lsr1",   32'h8000_0001, 5'd1,  SHR_LSR,  32'h4000_0000, 1'b1);
        run_one("asr31",  32'h8000_0000, 5'd31, SHR_ASR,  32'hFFFF_FFFF, 1'b0);
        run_one("asr4",   32'h7FFF_FFFF, 5'd4,  SHR_ASR,  32'h07FF_FFFF, 1'b1);
        run_one("ror1",   32'h0000_0001, 5'd1,  SHR_ROR,  32'h8000_0000, 1'b1);
        run_one("ror16",  32'h1234_5678, 5'd16, SHR_ROR,  32'h5678_1234, 1'b0);
        run_one("pass7",  32'hDEAD_BEEF, 5'd7,  SHR_PASS, 32'hDEAD_BEEF, 1'b0);
        run_one("lsr0",   32'hA5A5_A5A5, 5'd0,  SHR_LSR,  32'hA5A5_A5A5, 1'b0);
        run_one("asr0",   32'hA5A5_A5A5, 5'd0,  SHR_ASR,  32'hA5A5_A5A5, 1'b0);
        run_one("ror0",   32'hA5A5_A5A5, 5'd0,  SHR_ROR,  32'hA5A5_A5A5, 1'b0);
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, low = 0;
        logic [31:0] r, er;
        logic c, ec;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (sent < 8) begin
                in_valid = 1'b1; in_a = $urandom; in_shift = 5'($urandom_range(31));
                in_op = 2'($urandom_range(3));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(cyc >= 6 && cyc < 9);
            @(negedge clk);
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                failures++; $display("FAIL b2b_in_ready cyc%0d: got %b expected %b",
                                     cyc, in_ready, !(out_valid && !out_ready));
            end
            if (!in_ready) low++;
            if (in_valid && in_ready) begin
                ref_shift(in_a, int'(in_shift), in_op, r, c);
                q_res.push_back(r); q_c.push_back(c); sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q_res.size() == 0) begin
                    failures++; $display("FAIL b2b_extra: got %h expected none", out_result);
                end else begin
                    er = q_res.pop_front(); ec = q_c.pop_front(); got++;
                    if ({out_result, out_carry} !== {er, ec}) begin
                        failures++; $display("FAIL b2b_data #%0d: got %h/%b expected %h/%b",
                                             got, out_result, out_carry, er, ec);
                    end
                end
            end
        end
        checks++;
        if (low !== 3) begin
            failures++; $display("FAIL b2b_stall_cycles: got %0d expected 3", low);
        end
        checks++;
        if (got !== 8) begin
            failures++; $display("FAIL b2b_count: got %0d expected 8", got);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_random();
        int n_ops = 60;
        int sent = 0, got = 0, cyc = 0;
        bit acc = 1'b0;
        logic [31:0] r, er;
        logic c, ec;
        fork
            begin
                while (sent < n_ops) begin
                    @(posedge clk); #1;
                    if (acc || !in_valid) begin
                        in_valid = ($urandom_range(3) != 0);
                        in_a     = $urandom;
                        case ($urandom_range(3))
                            0: in_shift = 5'd0;
                            1: in_shift = 5'd31;
                            default: in_shift = 5'($urandom_range(31));
                        endcase
                        in_op = 2'($urandom_range(3));
                    end
                    @(negedge clk);
                    acc = in_valid && in_ready;
                    if (acc) begin
                        ref_shift(in_a, int'(in_shift), in_op, r, c);
                        q_res.push_back(r); q_c.push_back(c); sent++;
                    end
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                while (got < n_ops && cyc < 3000) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(3) != 0);
                    cyc++;
                    @(negedge clk);
                    checks++;
                    if (in_ready !== !(out_valid && !out_ready)) begin
                        failures++; $display("FAIL rnd_in_ready: got %b expected %b",
                                             in_ready, !(out_valid && !out_ready));
                    end
                    if (out_valid && out_ready) begin
                        checks++;
                        if (q_res.size() == 0) begin
                            failures++; $display("FAIL rnd_extra: got %h expected none", out_result);
                        end else begin
                            er = q_res.pop_front(); ec = q_c.pop_front(); got++;
                            if ({out_result, out_carry} !== {er, ec}) begin
                                failures++; $display("FAIL rnd_data #%0d: got %h/%b expected %h/%b",
                                                     got, out_result, out_carry, er, ec);
                            end
                        end
                    end
                end
            end
        join
        checks++;
        if (got !== n_ops) begin
            failures++; $display("FAIL rnd_count: got %0d expected %0d", got, n_ops);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_flush();
        int seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = $urandom; in_shift = 5'($urandom_range(31));
            in_op = 2'($urandom_range(3)); out_ready = 1'b1;
        end
        @(posedge clk); #1;
        flush = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            failures++; $display("FAIL flush_cycle: got v=%b rdy=%b expected v=1 rdy=0",
                                 out_valid, in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_next: got %b expected 0", out_valid);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL flush_drain: got %0d valid cycles expected 0", seen);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = $urandom | 32'h1; in_shift = 5'($urandom_range(31));
            in_op = 2'($urandom_range(3)); out_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL midrst_pre: got %b expected 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_result, out_carry, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL midrst: got v=%b r=%h c=%b rdy=%b expected v=0 r=0 c=0 rdy=1",
                     out_valid, out_result, out_carry, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_one("post_rst", 32'h0000_0010, 5'd4, SHR_LSR, 32'h0000_0001, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
